// File: rtl/tcp_tx_route_tag.sv
// rtl/tcp_tx_route_tag.sv - TX egress stage that tags packets with a per-packet latched route
//
// Purpose: registers the network-side TX stream toward the vIO switch, latching
// the route ID at each packet's first beat so tid/tdest stay constant through
// tlast. A first beat is stalled until a valid route is shown; if none appears
// within TIMEOUT cycles the whole packet is sunk and counted as a drop.
//
// Ports:
//   aclk, aresetn                  clock, asynchronous active-low reset
//   s_axis_*                       input stream (tvalid/tready/tdata/tkeep/tlast)
//   route_id, route_id_valid       route of the current TX connection
//   m_axis_*                       registered output stream with tid/tdest
//   pkt_cnt, beat_cnt, drop_cnt    saturating status counters

module tcp_tx_route_tag #(
    parameter int DATA_BITS  = 512,
    parameter int ROUTE_BITS = 14,
    parameter int ID_BITS    = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_BITS   = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_BITS-1:0]    s_axis_tdata,
    input  logic [DATA_BITS/8-1:0]  s_axis_tkeep,
    input  logic                    s_axis_tlast,

    input  logic [ROUTE_BITS-1:0]   route_id,
    input  logic                    route_id_valid,

    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_BITS-1:0]    m_axis_tdata,
    output logic [DATA_BITS/8-1:0]  m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [ID_BITS-1:0]      m_axis_tid,
    output logic [ROUTE_BITS-1:0]   m_axis_tdest,

    output logic [CNT_BITS-1:0]     pkt_cnt,
    output logic [CNT_BITS-1:0]     beat_cnt,
    output logic [CNT_BITS-1:0]     drop_cnt
);

    localparam int TMR_BITS = $clog2(TIMEOUT);
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FWD,
        S_DROP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [TMR_BITS-1:0]    timer;
    logic [TMR_BITS-1:0]    timer_nxt;
    logic [ROUTE_BITS-1:0]  rt_q;
    logic [ROUTE_BITS-1:0]  beat_rt;
    logic                   ready_en;
    logic                   loadable;
    logic                   accept;
    logic                   fwd_beat;
    logic                   first_beat;
    logic                   drop_done;
    logic                   out_hs;

    assign loadable = !m_axis_tvalid || m_axis_tready;
    assign accept   = s_axis_tvalid && s_axis_tready;
    assign out_hs   = m_axis_tvalid && m_axis_tready;

    // The first beat takes the live route; later beats reuse the latched one.
    assign beat_rt    = first_beat ? route_id : rt_q;
    assign m_axis_tid = m_axis_tdest[ID_BITS-1:0];

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        s_axis_tready = 1'b0;
        fwd_beat      = 1'b0;
        first_beat    = 1'b0;
        drop_done     = 1'b0;
        case (state)
            S_IDLE, S_WAIT: begin
                // ready_en keeps tready low for the first cycle out of reset,
                // so the reset value is 0 even with route_id_valid high.
                s_axis_tready = ready_en && route_id_valid && loadable;
                if (route_id_valid) begin
                    if (accept) begin
                        fwd_beat   = 1'b1;
                        first_beat = 1'b1;
                        state_nxt  = s_axis_tlast ? S_IDLE : S_FWD;
                    end
                end else if (state == S_IDLE) begin
                    if (s_axis_tvalid) begin
                        state_nxt = S_WAIT;
                        timer_nxt = '0;
                    end
                end else if (timer == TMR_LAST) begin
                    state_nxt = S_DROP;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_FWD: begin
                s_axis_tready = loadable;
                if (accept) begin
                    fwd_beat = 1'b1;
                    if (s_axis_tlast) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                s_axis_tready = 1'b1;
                if (accept && s_axis_tlast) begin
                    drop_done = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            timer    <= '0;
            rt_q     <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            ready_en <= 1'b1;
            if (first_beat) begin
                rt_q <= route_id;
            end
        end
    end

    // Output register: payload and tags only load together with a new beat,
    // so they hold while the downstream stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= '0;
        end else if (fwd_beat) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tdest  <= beat_rt;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (out_hs && beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (out_hs && m_axis_tlast && pkt_cnt != '1) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (drop_done && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/tcp_tx_route_tag.md
# tcp_tx_route_tag

Registered TX egress stage between the TCP arbiter's network-side TX stream and the vIO switch. Captures the route ID at the first beat of each packet and holds `tid`/`tdest` stable through `tlast`, so mid-packet route-ID changes are ignored. Stalls a packet's first beat until a valid route is presented, and drops the whole packet if none arrives within a timeout. Keeps saturating packet, beat and drop counters for status registers.

## Interface
Parameters:
- `DATA_BITS`, default `AXI_NET_BITS` (512): stream data width; `tkeep` is `DATA_BITS/8`.
- `ROUTE_BITS`, default 14: route ID / `tdest` width.
- `ID_BITS`, default `N_REGIONS_BITS`: `tid` width; `tid` is the low `ID_BITS` of the route ID.
- `TIMEOUT`, default 1024: cycles to wait for a valid route before dropping; must be ≥ 2.
- `CNT_BITS`, default 32: status counter width.

Ports:
- `aclk`  in  1  clock; the only clock.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `s_axis_tvalid` / `s_axis_tready`  in / out  1 / 1  input stream handshake.
- `s_axis_tdata` / `s_axis_tkeep` / `s_axis_tlast`  in  `DATA_BITS` / `DATA_BITS/8` / 1  input stream payload.
- `route_id`  in  `ROUTE_BITS`  route ID of the current TX connection.
- `route_id_valid`  in  1  `route_id` is usable.
- `m_axis_tvalid` / `m_axis_tready`  out / in  1 / 1  output stream handshake.
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tlast`  out  as input  registered payload.
- `m_axis_tid`  out  `ID_BITS`  latched `route_id[ID_BITS-1:0]`.
- `m_axis_tdest`  out  `ROUTE_BITS`  latched `route_id`.
- `pkt_cnt`  out  `CNT_BITS`  packets forwarded (counted at `tlast` acceptance).
- `beat_cnt`  out  `CNT_BITS`  beats forwarded.
- `drop_cnt`  out  `CNT_BITS`  packets dropped on timeout.

## Operation
- Output register holds one beat plus its latched `tid`/`tdest`. Loadable when `!m_axis_tvalid || m_axis_tready`.
- FSM states:
  - **IDLE** (at packet boundary).
    - `s_axis_tvalid && route_id_valid`: latch `route_id` into `rt_q`. Accept the beat when the output register is loadable. Next state is FWD if `!tlast`, else IDLE.
    - `s_axis_tvalid && !route_id_valid`: go to WAIT, clear the timer, `s_axis_tready=0`.
  - **WAIT**: `s_axis_tready=0`; the timer increments each cycle.
    - `route_id_valid`: behaves as the IDLE accept case in the same cycle, including the route latch.
    - `route_id_valid` low with timer == `TIMEOUT-1`: go to DROP. No beat is accepted in that cycle.
    - Route-valid takes priority over timeout in the same cycle.
  - **FWD**: `s_axis_tready` = output loadable. Beats carry `rt_q`. The `route_id` input is ignored. Accepting `tlast` returns to IDLE.
  - **DROP**: `s_axis_tready=1`; beats are discarded and no output is produced. Accepting `tlast` increments `drop_cnt` and returns to IDLE.
- `rt_q` changes only at first-beat acceptance, so `m_axis_tid`/`m_axis_tdest` are constant for every beat of a packet.
- Counters saturate at all-ones.
  - `beat_cnt` increments on each output handshake.
  - `pkt_cnt` increments on an output handshake with `tlast`.
- A packet whose first beat is `tlast` is a single-beat packet. All rules apply unchanged.
- `tkeep` is passed through unmodified; no zero-keep filtering.

## Timing
- Reset values: all outputs are 0, `s_axis_tready=0`, state IDLE, timer and counters 0.
- Reset assertion mid-packet clears `m_axis_tvalid` asynchronously. Downstream sees a truncated packet; the block performs no recovery.
- Latency is 1 cycle from input acceptance to `m_axis_tvalid`. Throughput is 1 beat/cycle in FWD when `m_axis_tready` is held high.
- `s_axis_tready` is combinational from state, `route_id_valid`, `m_axis_tvalid` and `m_axis_tready`. There is no path from `s_axis_tvalid` to `s_axis_tready`.
- Output payload, `tid` and `tdest` hold stable while `m_axis_tvalid && !m_axis_tready`.
- WAIT lasts at most `TIMEOUT` cycles. DROP entry occurs `TIMEOUT` cycles after WAIT entry.

## Test plan
- 4-beat packet, `route_id=0x2A5`, valid, `m_axis_tready=1`:
  - 4 output beats starting 1 cycle after the first accept.
  - `tdest=0x2A5`, `tid=0x5` (for `ID_BITS=4`).
  - `pkt_cnt=1`, `beat_cnt=4`.
- `route_id` changes to `0x011` after beat 1 of an 8-beat packet: all 8 beats carry `tdest=0x2A5`. The next packet carries `0x011`.
- `route_id_valid` low for 10 cycles at packet start (`TIMEOUT=1024`): `s_axis_tready=0` for 10 cycles, then the packet is forwarded intact and `drop_cnt=0`.
- `route_id_valid` never asserted with `TIMEOUT=16`, 3-beat packet:
  - DROP is entered after 16 cycles and the 3 beats are sunk.
  - No `m_axis_tvalid`, `drop_cnt=1`.
  - The following valid-route packet forwards normally.
- Random `m_axis_tready` backpressure (50%) over 100 packets of 1–16 beats:
  - Output matches input beat-for-beat, with payload stable during stalls.
  - `beat_cnt` equals total beats.
- `aresetn` pulsed low during beat 2 of a 5-beat packet:
  - All outputs are 0 immediately.
  - After release the next packet starts in IDLE, re-latches its route, and counters restart from 0.
